// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants for the sequential restoring divider.
// Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step (shift, compare, subtract).
// Revision    : 1.0  initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic           w_ge;

    assign w_shift = {rem[WIDTH-1:0], dvd_msb};
    // A set top bit would already put the shifted value above any divisor.
    assign w_ge    = rem[WIDTH] | (w_shift >= {1'b0, divisor});

    assign rem_next = w_ge ? (w_shift - {1'b0, divisor}) : w_shift;
    assign q_bit    = w_ge;

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_rem),
        .dvd_msb  (r_dvd[WIDTH-1]),
        .divisor  (r_dvs),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // Dividend register doubles as the quotient: bits leave at the top as
    // quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd <= A;
                        r_dvs <= B;
                        r_rem <= '0;
                        if (B != '0) begin
                            r_state <= ST_RUN;
                            r_cnt   <= CW'(WIDTH);
                        end else begin
                            r_state <= ST_DONE;
                            r_q     <= '1;
                            r_r     <= A;
                            r_dbz   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_DONE;
                        r_q     <= {r_dvd[WIDTH-2:0], w_q_bit};
                        r_r     <= w_rem_next[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign dbz  = r_dbz;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic reference.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    // Issues one start pulse from IDLE and returns cycles until done plus busy cycles seen.
    task automatic run_div(input int a, input int b, output int lat, output int busy_cnt);
        @(negedge clk);
        A = W'(a); B = W'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        lat = 1; busy_cnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #2;
        checks++;
        if ({Q, R, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_state: got Q=%0d R=%0d busy=%b done=%b dbz=%b, want all 0", Q, R, busy, done, dbz);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int va[4] = '{13, 15, 2, 0};
        int vb[4] = '{3, 1, 7, 5};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, bc);
            checks++;
            if (lat !== 5) begin
                errors++; $display("FAIL basic_latency %0d/%0d: got %0d want 5", va[i], vb[i], lat);
            end
            checks++;
            if (bc !== 4) begin
                errors++; $display("FAIL basic_busy %0d/%0d: got %0d want 4", va[i], vb[i], bc);
            end
            checks++;
            if (Q !== ref_q(va[i], vb[i]) || R !== ref_r(va[i], vb[i]) || dbz !== 1'b0) begin
                errors++;
                $display("FAIL basic_result %0d/%0d: got Q=%0d R=%0d dbz=%b want Q=%0d R=%0d dbz=0",
                         va[i], vb[i], Q, R, dbz, ref_q(va[i], vb[i]), ref_r(va[i], vb[i]));
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || Q !== ref_q(va[i], vb[i]) || R !== ref_r(va[i], vb[i])) begin
                errors++;
                $display("FAIL basic_hold %0d/%0d: got done=%b Q=%0d R=%0d want done=0 and held results",
                         va[i], vb[i], done, Q, R);
            end
        end
    endtask

    task automatic test_dbz();
        int lat, bc;
        run_div(9, 0, lat, bc);
        checks++;
        if (lat !== 1 || bc !== 0) begin
            errors++; $display("FAIL dbz_timing: got latency=%0d busy_cycles=%0d want 1 and 0", lat, bc);
        end
        checks++;
        if (Q !== 4'd15 || R !== 4'd9 || dbz !== 1'b1) begin
            errors++; $display("FAIL dbz_result: got Q=%0d R=%0d dbz=%b want Q=15 R=9 dbz=1", Q, R, dbz);
        end
    endtask

    task automatic test_ignore_start();
        int t, lat, bc;
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd6; B = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20 || Q !== 4'd4 || R !== 4'd1 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got Q=%0d R=%0d dbz=%b wait=%0d want Q=4 R=1 dbz=0", Q, R, dbz, t);
        end
        run_div(6, 2, lat, bc);
        checks++;
        if (Q !== 4'd3 || R !== 4'd0 || dbz !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL after_ignore: got Q=%0d R=%0d dbz=%b lat=%0d want Q=3 R=0 dbz=0 lat=5", Q, R, dbz, lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen, lat, bc;
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midreset_busy: got busy=%b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({Q, R, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got Q=%0d R=%0d busy=%b done=%b dbz=%b want all 0", Q, R, busy, done, dbz);
        end
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d done cycles want 0", seen);
        end
        run_div(14, 4, lat, bc);
        checks++;
        if (Q !== 4'd3 || R !== 4'd2 || lat !== 5) begin
            errors++; $display("FAIL midreset_recover: got Q=%0d R=%0d lat=%0d want Q=3 R=2 lat=5", Q, R, lat);
        end
    endtask

    task automatic test_random();
        int a, b, lat, bc;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            run_div(a, b, lat, bc);
            checks++;
            if (Q !== ref_q(a, b) || R !== ref_r(a, b) || dbz !== (b == 0) || lat !== ((b == 0) ? 1 : 5)) begin
                errors++;
                $display("FAIL random %0d/%0d: got Q=%0d R=%0d dbz=%b lat=%0d want Q=%0d R=%0d dbz=%b lat=%0d",
                         a, b, Q, R, dbz, lat, ref_q(a, b), ref_r(a, b), (b == 0), (b == 0) ? 1 : 5);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, last_cyc, t, a, b;
        @(negedge clk);
        A = '0; B = '0; start = 1'b1;
        cyc = 0; last_cyc = 0;
        for (int k = 0; k < 256; k++) begin
            a = k >> 4;
            b = k & 15;
            t = 0;
            while (done !== 1'b1 && t < 20) begin
                @(negedge clk);
                cyc++;
                t++;
            end
            checks++;
            if (t >= 20) begin
                errors++;
                $display("FAIL b2b_timeout pair %0d/%0d: no done within 20 cycles", a, b);
                start = 1'b0;
                return;
            end
            checks++;
            if (Q !== ref_q(a, b) || R !== ref_r(a, b) || dbz !== (b == 0)) begin
                errors++;
                $display("FAIL b2b_result %0d/%0d: got Q=%0d R=%0d dbz=%b want Q=%0d R=%0d dbz=%b",
                         a, b, Q, R, dbz, ref_q(a, b), ref_r(a, b), (b == 0));
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_cyc !== ((b == 0) ? 2 : 6)) begin
                    errors++;
                    $display("FAIL b2b_spacing %0d/%0d: got %0d want %0d", a, b, cyc - last_cyc, (b == 0) ? 2 : 6);
                end
            end
            last_cyc = cyc;
            if (k < 255) begin
                A = W'((k + 1) >> 4);
                B = W'((k + 1) & 15);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
